// File: rtl/counter_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// counter_sequencer_pkg
//   Shared encodings for the counter run-control sequencer.
//   - state_t  : sequencer state as seen on the 'state' output bus
//   - op_t     : command op-codes carried on 'cmd_op'
//   - TC_RESET : terminal-count reset value (all-ones, sliced to WIDTH by users)
// -----------------------------------------------------------------------------
package counter_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      OP_START = 2'b00,
      OP_STOP  = 2'b01,
      OP_CLEAR = 2'b10,
      OP_LOAD  = 2'b11
   } op_t;

   // Wide enough for any practical WIDTH; consumers take the low WIDTH bits.
   localparam logic [31:0] TC_RESET = '1;

endpackage : counter_sequencer_pkg

// File: rtl/counter_datapath.sv
// -----------------------------------------------------------------------------
// counter_datapath
//   Count register plus programmable terminal-count register and comparator.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     clr         : force count to 0 (wins over inc)
//     inc         : count <= count + 1 (modulo 2^WIDTH)
//     load        : tc <= load_data
//     load_data   : new terminal-count value
//     count       : registered count
//     at_tc       : count equals current terminal count
// -----------------------------------------------------------------------------
module counter_datapath
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] count,
   output logic             at_tc
);

   logic [WIDTH-1:0] tc;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tc <= TC_RESET[WIDTH-1:0];
      end else if (load) begin
         tc <= load_data;
      end
   end

   // Compares against the pre-edge tc, so a LOAD coinciding with a tick
   // evaluates that tick against the old terminal count.
   assign at_tc = (count == tc);

endmodule : counter_datapath

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//   Run-control FSM for an up-counter: accepts START/STOP/CLEAR/LOAD over a
//   valid/ready handshake, advances the count on tick_en while running, and
//   stops (one-shot) or wraps to 0 (auto-reload) at the terminal count.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     cmd_valid    : command present
//     cmd_ready    : command may be accepted this cycle (drops 1 cycle per accept)
//     cmd_op       : 00 START, 01 STOP, 10 CLEAR, 11 LOAD
//     cmd_data     : terminal-count value for LOAD
//     mode_reload  : 1 = auto-reload at terminal count, 0 = one-shot
//     tick_en      : count advance qualifier
//     count        : registered count
//     state        : 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//     done         : registered one-cycle pulse after a terminal tick
// -----------------------------------------------------------------------------
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             mode_reload,
   input  logic             tick_en,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state,
   output logic             done
);

   state_t state_q, state_d;
   logic   ready_q;
   logic   done_q, done_d;
   logic   accept;
   logic   cnt_clr, cnt_inc, tc_load;
   logic   at_tc;

   assign accept = cmd_valid & ready_q;

   counter_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk       (clk),
      .rst       (rst),
      .clr       (cnt_clr),
      .inc       (cnt_inc),
      .load      (tc_load),
      .load_data (cmd_data),
      .count     (count),
      .at_tc     (at_tc)
   );

   // Tick handling is resolved first; an accepted command then overrides it
   // where the command must win (STOP/CLEAR while running).
   always_comb begin
      // NOTE: every output of this block gets a default before any branch, so
      // no path leaves a signal unassigned and no latch is inferred.
      state_d = state_q;
      done_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      tc_load = 1'b0;

      if (state_q == ST_RUN && tick_en) begin
         if (at_tc) begin
            done_d = 1'b1;
            if (mode_reload) cnt_clr = 1'b1;
            else             state_d = ST_DONE;
         end else begin
            cnt_inc = 1'b1;
         end
      end

      if (accept) begin
         case (op_t'(cmd_op))
            OP_LOAD: begin
               tc_load = 1'b1;
            end
            OP_START: begin
               // START in RUN is ignored; the tick above proceeds untouched.
               if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                  state_d = ST_RUN;
               end else if (state_q == ST_DONE) begin
                  cnt_clr = 1'b1;
                  state_d = ST_RUN;
               end
            end
            OP_STOP: begin
               if (state_q == ST_RUN) begin
                  state_d = ST_PAUSE;
                  cnt_inc = 1'b0;
                  cnt_clr = 1'b0;
                  done_d  = 1'b0;
               end else if (state_q == ST_DONE) begin
                  state_d = ST_IDLE;
               end
            end
            OP_CLEAR: begin
               cnt_clr = 1'b1;
               cnt_inc = 1'b0;
               done_d  = 1'b0;
               state_d = (state_q == ST_RUN) ? ST_RUN : ST_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // One bubble after every accept caps the rate at one command per two cycles.
         ready_q <= ~accept;
         done_q  <= done_d;
      end
   end

   assign cmd_ready = ready_q;
   assign state     = state_q;
   assign done      = done_q;

endmodule : counter_sequencer

// File: doc/counter_sequencer.md
# counter_sequencer

Run-control sequencer for the 8-bit free-running counter datapath. It accepts start/stop/clear/load commands over a valid/ready handshake and gates counter advance with an external tick enable. It compares the count against a programmable terminal count and runs either one-shot or auto-reload. It sits between the pin-level control inputs and the counter, and drives the count onto the output bus.

## Interface
- `WIDTH`, default 8: counter and terminal-count width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command may be accepted this cycle.
- `cmd_op`  in  2: 00 START, 01 STOP, 10 CLEAR, 11 LOAD.
- `cmd_data`  in  WIDTH: terminal-count value for LOAD; ignored otherwise.
- `mode_reload`  in  1: 1 = auto-reload at terminal count, 0 = one-shot. Sampled on each terminal tick.
- `tick_en`  in  1: advance qualifier; the count steps only on cycles with `tick_en`=1 in RUN.
- `count`  out  WIDTH: current count, registered.
- `state`  out  2: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- `done`  out  1: one-cycle pulse on terminal count.

## Operation
- A command is accepted on an edge where `cmd_valid`=1 and `cmd_ready`=1.
- `cmd_ready` drops for exactly one cycle after each accepted command, so the maximum rate is one command every two cycles.
- A stalled command must remain stable until it is accepted.
- Terminal tick: in RUN, with `tick_en`=1 and `count`==`tc`.
  - `done` pulses.
  - If `mode_reload`=1: `count` goes to 0 and state stays RUN.
  - If `mode_reload`=0: `count` holds at `tc` and state goes to DONE.
- Non-terminal tick in RUN: `count` increments by 1, modulo 2^WIDTH.
  - If `tc` is below the current count, the counter wraps through all-ones to 0 and continues until it equals `tc`.
- LOAD: `tc` ← `cmd_data` in every state. State and count are unchanged.
- State transitions. Any command/state pair not listed has no effect.
  - IDLE: START → RUN, count unchanged. CLEAR → count=0, stay IDLE.
  - RUN: STOP → PAUSE. CLEAR → count=0, stay RUN.
  - PAUSE: START → RUN. CLEAR → count=0, go to IDLE.
  - DONE: START → count=0, go to RUN. CLEAR → count=0, go to IDLE. STOP → IDLE, count held.
- Simultaneous command and tick in RUN:
  - STOP or CLEAR: the command wins and no increment occurs that cycle.
  - LOAD: the tick is evaluated against the old `tc`; the new `tc` applies from the next cycle.
  - START: ignored; the tick is processed normally.
- `tc`=0 is legal: the first tick from count 0 is terminal.

## Timing
- Reset values (asynchronous, effective immediately and independent of `clk`):
  - `count`=0, `tc`=all-ones, `state`=IDLE, `done`=0, `cmd_ready`=1.
- Reset asserted mid-RUN aborts the run. After release, the block waits in IDLE for START.
- A command accepted at edge N takes effect on `state`/`count` after edge N. `cmd_ready`=0 during cycle N+1 and is 1 again after edge N+1.
- Tick latency: the count is updated on the same edge that samples `tick_en`.
- `done` is registered. It is high for exactly the one cycle after the terminal-tick edge and is never high on two consecutive cycles unless `tc`=0 with reload and `tick_en` held at 1.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Structure
- Package `counter_sequencer_pkg`:
  - state encoding constants (IDLE/RUN/PAUSE/DONE),
  - op-code constants (START/STOP/CLEAR/LOAD),
  - `TC_RESET` = all-ones.
- Sub-module `counter_datapath`:
  - count register with `clr` and `inc` controls,
  - `tc` register with `load`,
  - terminal compare output `at_tc`.
- `counter_sequencer` holds the FSM, handshake and `done` logic, and drives the datapath controls.

## Test plan
- Reset: assert `rst` mid-cycle → `count`=0, `state`=IDLE, `cmd_ready`=1 and `done`=0 immediately; after release, internal `tc`=255, so a START followed by 255 ticks reaches the terminal count.
- One-shot: LOAD 5, then START, `tick_en`=1, `mode_reload`=0 → count 0,1,2,3,4,5; `done` high for one cycle; `state`=DONE; count holds 5 for 20 further ticks.
- Reload: LOAD 3, START, `mode_reload`=1 → count sequence 0,1,2,3,0,1,2,3; `done` pulses every 4th tick.
- STOP with a simultaneous tick at count 2 → `state`=PAUSE, count stays 2; START then one tick → count 3.
- LOAD 1 while running at count 4 → count wraps 255→0→1, then `done` pulses; back-to-back `cmd_valid` sees `cmd_ready`=0 in the cycle after each accept, and the held command is accepted one cycle later.
- `tick_en` toggled 1,0,1,0 in RUN from count 0 → count advances only on the high cycles: 1,1,2,2.
